// File: rtl/dffram_arbiter_2p_if.sv
// One requester's channel into the DFFRAM arbiter: a valid/ready access
// request plus a single-cycle response strobe carrying read data.
interface dffram_arbiter_2p_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    localparam int WB = DW / 8;

    logic          valid;
    logic          ready;
    logic [WB-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/dffram_arbiter_2p.sv
// Round-robin arbiter sharing one single-port DFFRAM between two requesters,
// steering the RAM's one-cycle-latency read data back to the issuing port.
module dffram_arbiter_2p #(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic              CLK,
    input  logic              RESETn,
    dffram_arbiter_2p_if.slave p0,
    dffram_arbiter_2p_if.slave p1,
    output logic              ram_en,
    output logic [DW/8-1:0]   ram_we,
    output logic [AW-1:0]     ram_a,
    output logic [DW-1:0]     ram_di,
    input  logic [DW-1:0]     ram_do
);
    logic prio;           // 0: p0 wins a tie, 1: p1 wins a tie
    logic pend0, pend1;   // access accepted on the previous edge
    logic rd0, rd1;       // that access was a read
    logic gnt0, gnt1;

    // Reset gates the grant so nothing reaches the RAM while RESETn is low.
    always_comb begin
        gnt0 = RESETn & p0.valid & (~p1.valid | ~prio);
        gnt1 = RESETn & p1.valid & (~p0.valid | prio);
    end

    assign p0.ready = gnt0;
    assign p1.ready = gnt1;

    always_comb begin
        // NOTE: every output gets a default before the if, so no path leaves it unassigned and no latch is inferred.
        ram_en = gnt0 | gnt1;
        ram_we = '0;
        ram_a  = '0;
        ram_di = '0;
        if (gnt0) begin
            ram_we = p0.we;
            ram_a  = p0.addr;
            ram_di = p0.wdata;
        end else if (gnt1) begin
            ram_we = p1.we;
            ram_a  = p1.addr;
            ram_di = p1.wdata;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: state uses <= so every register samples pre-edge values regardless of statement order.
        if (!RESETn) begin
            prio  <= 1'b0;
            pend0 <= 1'b0;
            pend1 <= 1'b0;
            rd0   <= 1'b0;
            rd1   <= 1'b0;
        end else begin
            if (gnt0)      prio <= 1'b1;
            else if (gnt1) prio <= 1'b0;
            pend0 <= gnt0;
            pend1 <= gnt1;
            rd0   <= gnt0 & ~|p0.we;
            rd1   <= gnt1 & ~|p1.we;
        end
    end

    // Write responses and idle cycles return zero rather than stale RAM output.
    assign p0.rsp_valid = RESETn & pend0;
    assign p1.rsp_valid = RESETn & pend1;
    assign p0.rsp_rdata = (RESETn & pend0 & rd0) ? ram_do : '0;
    assign p1.rsp_rdata = (RESETn & pend1 & rd1) ? ram_do : '0;
endmodule

// File: doc/dffram_arbiter_2p.md
Name: dffram_arbiter_2p

Overview:
- Shares one single-port 256x32 DFFRAM macro between two independent requesters, e.g. CPU data port (p0) and DMA engine (p1).
- Each requester has a valid/ready request channel and a response strobe.
- The arbiter accepts at most one access per cycle, using round-robin priority, and drives the RAM's EN/WE/A/Di pins.
- It routes the RAM's 1-cycle-latency Do back to the requester that issued the read.

Parameters:
AW, 8, word address width (RAM depth = 2**AW)
DW, 32, data width; byte-enable width WB = DW/8

Ports:
CLK  in  1  clock, all state on rising edge
RESETn  in  1  synchronous, active-low reset, sampled on rising CLK
p0_valid  in  1  requester 0 access request
p0_ready  out  1  requester 0 access accepted this cycle
p0_we  in  WB  byte write enables; 0 = read
p0_addr  in  AW  word address
p0_wdata  in  DW  write data
p0_rsp_valid  out  1  one-cycle response strobe
p0_rsp_rdata  out  DW  read data, qualified by p0_rsp_valid
p1_valid, p1_ready, p1_we, p1_addr, p1_wdata, p1_rsp_valid, p1_rsp_rdata: same as p0, for requester 1
ram_en  out  1  to DFFRAM EN0
ram_we  out  WB  to DFFRAM WE0
ram_a  out  AW  to DFFRAM A0
ram_di  out  DW  to DFFRAM Di0
ram_do  in  DW  from DFFRAM Do0; valid the cycle after an EN0=1, WE0=0 edge

Behaviour:
- Reset (RESETn=0 at an edge): prio<=0 (p0 favoured), pend0/pend1<=0, rd0/rd1<=0.
- While RESETn=0: p*_ready=0, ram_en=0, ram_we=0, p*_rsp_valid=0, p*_rsp_rdata=0.
- Grant logic is combinational from p*_valid and the prio register.
  - Only one requester valid: it is granted.
  - Both valid: the port indicated by prio is granted.
  - Neither valid: no grant; ram_en=0, ram_we=0, ram_a/ram_di hold 0.
- p*_ready equals the grant for that port. Accept = valid & ready at a rising edge.
- On a grant, ram_en=1 and ram_we/ram_a/ram_di are muxed combinationally from the granted port in the same cycle. There is no request-side register.
- prio update: after an accept by port p, prio<=~p. Without an accept, prio holds.
  - Result: continuous dual requests alternate 0,1,0,1…
  - Maximum wait for a valid requester is 1 cycle.
- Response tracking, per port: on accept, pend_p<=1 and rd_p<=(we==0). Otherwise pend_p<=0.
- p_rsp_valid = pend_p (registered). It is exactly one cycle, one cycle after accept, for both reads and writes.
  - Reads: p_rsp_rdata = ram_do.
  - Writes: p_rsp_rdata = 0.
  - When p_rsp_valid=0, p_rsp_rdata = 0.
- Back-to-back accepts are allowed: sustained throughput is 1 access/cycle total. A response and a new accept may coincide for the same or the other port.
- Only one of p0_rsp_valid / p1_rsp_valid is ever high in a cycle.
- Partial writes: ram_we passes through unchanged. Byte merging is done by the RAM.
- Protocol rule (bench asserts it, RTL does not check it): a requester holds valid/we/addr/wdata stable while valid & ~ready.
- Reset mid-operation: RESETn=0 at the edge following an accept clears pend. No response is issued for that access, and any write already sampled by the RAM stands.
- Width rules: addresses are used modulo 2**AW with no wrap logic. Address 255 followed by 0 needs no special handling.

Test Plan:
- Reset: hold RESETn=0 for 3 cycles with p0_valid=p1_valid=1 -> p*_ready=0, ram_en=0, p*_rsp_valid=0. On the first cycle after release, p0_ready=1 and p1_ready=0.
- Write then cross-port read: p0 writes addr 0x10, we=0xF, data 0xDEADBEEF -> p0_rsp_valid=1 next cycle with rdata 0. p1 then reads 0x10 -> p1_rsp_valid=1 one cycle after accept with rdata 0xDEADBEEF.
- Contention: both ports valid for 6 consecutive cycles, reads to 0x00/0x01 -> grants p0,p1,p0,p1,p0,p1. Each rsp arrives on the correct port with correct data. Exactly one ram_en access per cycle.
- Byte write: write 0x11223344 to 0xFF, then write we=0x2 data 0x0000AA00 to 0xFF, then read 0xFF -> rdata 0x1122AA44. Then read 0x00 -> no address wrap artefact.
- Idle and single requester: only p1 valid for 4 cycles -> p1 granted every cycle regardless of prio. Then both valid -> p0 granted first (prio toggled to 0 by last p1 accept).
- Reset mid-op: p0 read accepted, RESETn=0 at the next edge -> p0_rsp_valid stays 0. After release, prio=0 and no stale response.
